kmp_stream_matcher: RTL and testbench

//  Runtime-configurable KMP substring counter: next generation of the fixed 4-byte matcher.

---
 rtl/kmp_stream_matcher.sv | 164 ++++++++++++++++
 tb/tb_kmp_stream_matcher.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmp_stream_matcher.sv
// Runtime-configurable KMP substring counter: loads a pattern, builds its failure table
// on-chip, then scans a valid/ready text stream and reports each match end position.
module kmp_stream_matcher #(
   parameter int MAX_PAT = 16,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 32,
   localparam int PW     = $clog2(MAX_PAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pat_we,
   input  logic [PW-1:0]     pat_waddr,
   input  logic [DATA_W-1:0] pat_wdata,
   input  logic [PW-1:0]     pat_len,
   input  logic              overlap,
   input  logic              start,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              match_valid,
   input  logic              match_ready,
   output logic [CNT_W-1:0]  match_pos,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  n_matches
);
   localparam int IW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_CPF, S_WAIT, S_SCAN, S_STEP, S_EMIT, S_DONE
   } state_t;
   state_t state, state_n;

   logic [DATA_W-1:0] pat      [MAX_PAT];
   logic [PW-1:0]     fail_tab [MAX_PAT];
   logic [PW-1:0]     len, q, k, cq, k_eq;
   logic              ovl, last;
   logic [DATA_W-1:0] sym, pat_k, pat_cq, pat_q;
   logic [CNT_W-1:0]  idx, cnt;
   logic              len_bad, cpf_fall, q_fall, step_hit, full_hit;

   always_comb begin
      pat_k    = pat[IW'(k)];
      pat_cq   = pat[IW'(cq)];
      pat_q    = pat[IW'(q)];
      len_bad  = (pat_len == '0) || (pat_len > PW'(MAX_PAT));
      cpf_fall = (k != '0) && (pat_k != pat_cq);
      k_eq     = k + PW'(pat_k == pat_cq);
      q_fall   = (q != '0) && (pat_q != sym);
      step_hit = (pat_q == sym);
      full_hit = step_hit && (q == len - PW'(1));
   end

   // Both streams use plain valid/ready: a word moves on a rising edge where valid and
   // ready are both high; the producer holds valid and data stable until that edge.
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: if (start) state_n = len_bad ? S_ERR : S_CPF;
         S_ERR:  state_n = S_IDLE;
         S_CPF:  if (cq == len) state_n = S_WAIT;
         S_WAIT: if (in_valid && in_ready) state_n = S_SCAN;
         S_SCAN: if (!q_fall) state_n = S_STEP;
         S_STEP: begin
            if (full_hit) state_n = S_EMIT;
            else          state_n = last ? S_DONE : S_WAIT;
         end
         S_EMIT: if (match_ready) state_n = last ? S_DONE : S_WAIT;
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Pattern and failure table are storage only; the table is rebuilt on every start.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && pat_we && pat_waddr < PW'(MAX_PAT))
         pat[IW'(pat_waddr)] <= pat_wdata;
      if (state == S_IDLE && start && !len_bad)
         fail_tab[0] <= '0;
      if (state == S_CPF && cq != len && !cpf_fall)
         fail_tab[IW'(cq)] <= k_eq;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len         <= '0;
         ovl         <= 1'b0;
         q           <= '0;
         k           <= '0;
         cq          <= '0;
         idx         <= '0;
         cnt         <= '0;
         sym         <= '0;
         last        <= 1'b0;
         match_pos   <= '0;
         n_matches   <= '0;
         busy        <= 1'b0;
         in_ready    <= 1'b0;
         match_valid <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         busy        <= (state_n != S_IDLE);
         in_ready    <= (state_n == S_WAIT);
         match_valid <= (state_n == S_EMIT);
         done        <= (state_n == S_DONE) || (state_n == S_ERR);
         err         <= (state_n == S_ERR);
         if (state_n == S_DONE) n_matches <= cnt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (len_bad) begin
                     n_matches <= '0;
                  end else begin
                     len <= pat_len;
                     ovl <= overlap;
                     cnt <= '0;
                     idx <= '0;
                     q   <= '0;
                     k   <= '0;
                     cq  <= PW'(1);
                  end
               end
            end
            S_CPF: begin
               if (cq != len) begin
                  if (cpf_fall) begin
                     k <= fail_tab[IW'(k - PW'(1))];
                  end else begin
                     k  <= k_eq;
                     cq <= cq + PW'(1);
                  end
               end
            end
            S_WAIT: begin
               if (in_valid && in_ready) begin
                  sym  <= in_data;
                  last <= in_last;
               end
            end
            S_SCAN: if (q_fall) q <= fail_tab[IW'(q - PW'(1))];
            S_STEP: begin
               idx <= idx + CNT_W'(1);
               if (full_hit) begin
                  cnt       <= cnt + CNT_W'(1);
                  match_pos <= idx;
                  // Overlap resumes from the longest border of the whole pattern.
                  q         <= ovl ? fail_tab[IW'(len - PW'(1))] : '0;
               end else if (step_hit) begin
                  q <= q + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_kmp_stream_matcher.sv
// Randomized bench for kmp_stream_matcher: a brute-force window-comparison model supplies
// expected match positions, counts and failure-table contents.
module tb_kmp_stream_matcher;
   localparam int MAX_PAT = 16;
   localparam int DATA_W  = 8;
   localparam int CNT_W   = 32;
   localparam int PW      = $clog2(MAX_PAT + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              pat_we;
   logic [PW-1:0]     pat_waddr;
   logic [DATA_W-1:0] pat_wdata;
   logic [PW-1:0]     pat_len;
   logic              overlap;
   logic              start;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              match_valid;
   logic              match_ready;
   logic [CNT_W-1:0]  match_pos;
   logic              done;
   logic              err;
   logic [CNT_W-1:0]  n_matches;

   kmp_stream_matcher #(.MAX_PAT(MAX_PAT), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .pat_we(pat_we), .pat_waddr(pat_waddr), .pat_wdata(pat_wdata),
      .pat_len(pat_len), .overlap(overlap), .start(start), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .match_valid(match_valid), .match_ready(match_ready), .match_pos(match_pos),
      .done(done), .err(err), .n_matches(n_matches)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] pat_m [MAX_PAT];
   logic [DATA_W-1:0] txt_m [$];
   logic [CNT_W-1:0]  exp_q [$];
   int                n_checks = 0;
   int                n_pass   = 0;
   bit                mon_en = 1'b0;
   bit                stall_mode = 1'b0;
   bit                stalled;
   int                stall_left = 0;
   logic [CNT_W-1:0]  stall_pos;
   int                ready_pct = 100;
   int                done_seen, err_seen, ready_seen;
   logic [CNT_W-1:0]  nm_seen;

   task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   // Scoreboard: drives match_ready for the coming edge, then checks what that edge accepts.
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_left > 0) begin
            match_ready = 1'b0;
            stall_left--;
            check("stall_valid", 32'(match_valid), 1);
            check("stall_pos", match_pos, stall_pos);
            check("stall_in_ready", 32'(in_ready), 0);
         end else if (stall_mode && !stalled && match_valid) begin
            match_ready = 1'b0;
            stalled     = 1'b1;
            stall_pos   = match_pos;
            stall_left  = 5;
         end else begin
            match_ready = ($urandom_range(99) < ready_pct);
         end
         if (in_ready) ready_seen++;
         if (match_valid && match_ready) begin
            check("match_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("match_pos", match_pos, exp_q.pop_front());
         end
         if (done) begin
            done_seen++;
            if (err) err_seen++;
            nm_seen = n_matches;
         end
      end
   end

   task automatic set_pat(input string s);
      for (int i = 0; i < s.len() && i < MAX_PAT; i++) pat_m[i] = s[i];
   endtask

   task automatic set_txt(input string s);
      txt_m.delete();
      for (int i = 0; i < s.len(); i++) txt_m.push_back(s[i]);
   endtask

   task automatic load_pat(input int plen);
      for (int i = 0; i < plen; i++) begin
         @(negedge clk);
         pat_we = 1'b1; pat_waddr = PW'(i); pat_wdata = pat_m[i];
      end
      @(negedge clk);
      pat_we = 1'b1; pat_waddr = PW'(MAX_PAT); pat_wdata = ~pat_m[0];
      @(negedge clk);
      pat_we = 1'b0;
   endtask

   task automatic feed(input logic [DATA_W-1:0] d, input bit lst, output bit ok);
      int wc;
      wc = 0;
      repeat ($urandom_range(2)) @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = lst;
      while (!in_ready && wc < 500) begin
         @(negedge clk);
         wc++;
      end
      ok = in_ready;
      if (!ok) check("tmo_in_ready", 32'(in_ready), 1);
      else @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run(input int plen, input int len_in, input bit ovl, input bit peek, input bit expect_err);
      int  last_end, wc, f, exp_n;
      bit  hit, ok;
      load_pat(plen);
      exp_q.delete();
      exp_n = 0;
      if (!expect_err) begin
         last_end = -1;
         for (int i = len_in - 1; i < txt_m.size(); i++) begin
            if (ovl || (i - len_in + 1 > last_end)) begin
               hit = 1'b1;
               for (int j = 0; j < len_in; j++)
                  if (txt_m[i - len_in + 1 + j] != pat_m[j]) hit = 1'b0;
               if (hit) begin
                  exp_q.push_back(CNT_W'(i));
                  last_end = i;
                  exp_n++;
               end
            end
         end
      end
      done_seen = 0; err_seen = 0; ready_seen = 0; stalled = 1'b0;
      mon_en = 1'b1;
      pat_len = PW'(len_in); overlap = ovl; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pat_we = 1'b1; pat_waddr = '0; pat_wdata = ~pat_m[0];
      @(negedge clk);
      pat_we = 1'b0;
      check("cpf_timing", 32'(in_ready), 32'(len_in == 1 && !expect_err));
      if (peek) begin
         wc = 0;
         while (!in_ready && wc < 200) begin
            @(negedge clk);
            wc++;
         end
         for (int i = 0; i < len_in; i++) begin
            f = 0;
            for (int l = 1; l <= i; l++) begin
               hit = 1'b1;
               for (int j = 0; j < l; j++) if (pat_m[j] != pat_m[i - l + 1 + j]) hit = 1'b0;
               if (hit) f = l;
            end
            check("fail_tab", CNT_W'(dut.fail_tab[i]), CNT_W'(f));
         end
      end
      if (!expect_err) begin
         for (int t = 0; t < txt_m.size(); t++) begin
            feed(txt_m[t], t == txt_m.size() - 1, ok);
            if (!ok) break;
         end
      end
      wc = 0;
      while (done_seen == 0 && wc < 1000) begin
         @(negedge clk);
         wc++;
      end
      repeat (3) @(negedge clk);
      check("done_pulses", done_seen, 1);
      check("err", err_seen, CNT_W'(expect_err));
      check("n_matches", nm_seen, CNT_W'(exp_n));
      check("missing_matches", exp_q.size(), 0);
      if (expect_err) check("in_ready_on_err", ready_seen, 0);
      mon_en = 1'b0;
   endtask

   initial begin
      bit ok;
      int L, tl, alpha, dn;
      rst = 1'b1; pat_we = 1'b0; pat_waddr = '0; pat_wdata = '0; pat_len = '0;
      overlap = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      match_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_match_valid", 32'(match_valid), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_match_pos", match_pos, 0);
      check("rst_n_matches", n_matches, 0);

      set_pat("ABAB"); set_txt("ABABAB");
      run(4, 4, 1'b1, 1'b0, 1'b0);
      run(4, 4, 1'b0, 1'b0, 1'b0);
      set_pat("A"); set_txt("AAA");
      run(1, 1, 1'b1, 1'b0, 1'b0);
      set_pat("AABAAA"); set_txt("AABAAAABAAABAABAAAAA");
      run(6, 6, 1'b1, 1'b1, 1'b0);
      run(0, 0, 1'b1, 1'b0, 1'b1);
      set_pat("ABABABABABABABAB");
      run(16, MAX_PAT + 1, 1'b1, 1'b0, 1'b1);

      set_pat("ABAB"); set_txt("ABABAB");
      stall_mode = 1'b1;
      run(4, 4, 1'b1, 1'b0, 1'b0);
      stall_mode = 1'b0;

      // Abort a run partway through the text.
      set_txt("ABABABAB");
      load_pat(4);
      match_ready = 1'b1;
      pat_len = PW'(4); overlap = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 5; t++) feed(txt_m[t], 1'b0, ok);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_in_ready", 32'(in_ready), 0);
      check("abort_match_valid", 32'(match_valid), 0);
      check("abort_done", 32'(done), 0);
      check("abort_err", 32'(err), 0);
      check("abort_match_pos", match_pos, 0);
      check("abort_n_matches", n_matches, 0);
      dn = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || err || match_valid) dn++;
      end
      check("abort_quiet", dn, 0);

      set_pat("AAAAAAAAAAAAAAAB"); set_txt("AAAAAAAAAAAAAAAAAAAAB");
      run(16, 16, 1'b1, 1'b0, 1'b0);

      for (int r = 0; r < 25; r++) begin
         L     = (r % 3 == 0) ? $urandom_range(1, MAX_PAT) : $urandom_range(1, 4);
         alpha = $urandom_range(1, 2);
         tl    = $urandom_range(5, 40);
         for (int i = 0; i < MAX_PAT; i++) pat_m[i] = DATA_W'(8'h41 + $urandom_range(alpha));
         txt_m.delete();
         for (int i = 0; i < tl; i++) txt_m.push_back(DATA_W'(8'h41 + $urandom_range(alpha)));
         ready_pct = $urandom_range(30, 100);
         run(L, L, 1'($urandom_range(1)), 1'(r % 5 == 0), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
